// File: rtl/gstmcu_snd_pkg.sv
// rtl/gstmcu_snd_pkg.sv - sound DMA register indices, control bits, state enum, byte helpers
package gstmcu_snd_pkg;

    localparam int unsigned ADDR_W = 21;

    localparam logic [4:0] REG_CTRL     = 5'd0;
    localparam logic [4:0] REG_START_HI = 5'd1;
    localparam logic [4:0] REG_START_MI = 5'd2;
    localparam logic [4:0] REG_START_LO = 5'd3;
    localparam logic [4:0] REG_CNT_HI   = 5'd4;
    localparam logic [4:0] REG_CNT_MI   = 5'd5;
    localparam logic [4:0] REG_CNT_LO   = 5'd6;
    localparam logic [4:0] REG_END_HI   = 5'd7;
    localparam logic [4:0] REG_END_MI   = 5'd8;
    localparam logic [4:0] REG_END_LO   = 5'd9;

    localparam int unsigned CTRL_PLAY_BIT = 0;
    localparam int unsigned CTRL_REP_BIT  = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } snd_state_e;

    // Word address bit n sits at byte address bit n+1.
    function automatic logic [7:0] addr_hi_byte(input logic [ADDR_W-1:0] a);
        return {2'b00, a[20:15]};
    endfunction

    function automatic logic [7:0] addr_mi_byte(input logic [ADDR_W-1:0] a);
        return a[14:7];
    endfunction

    function automatic logic [7:0] addr_lo_byte(input logic [ADDR_W-1:0] a);
        return {a[6:0], 1'b0};
    endfunction

endpackage

// File: rtl/snd_addr_reg.sv
// rtl/snd_addr_reg.sv - 21-bit word address register written and read as three byte lanes
module snd_addr_reg
    import gstmcu_snd_pkg::*;
(
    input  logic              clk32,
    input  logic              porb,
    input  logic              wr_hi,
    input  logic              wr_mi,
    input  logic              wr_lo,
    input  logic [7:0]        di,
    output logic [ADDR_W-1:0] q,
    output logic [7:0]        do_hi,
    output logic [7:0]        do_mi,
    output logic [7:0]        do_lo
);

    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk32 or negedge porb) begin
        if (!porb) begin
            addr_q <= '0;
        end else begin
            if (wr_hi) addr_q[20:15] <= di[5:0];
            if (wr_mi) addr_q[14:7]  <= di;
            if (wr_lo) addr_q[6:0]   <= di[7:1];
        end
    end

    assign q     = addr_q;
    assign do_hi = addr_hi_byte(addr_q);
    assign do_mi = addr_mi_byte(addr_q);
    assign do_lo = addr_lo_byte(addr_q);

endmodule

// File: rtl/snd_dma_addr.sv
// rtl/snd_dma_addr.sv - sound DMA frame address counter; SNDDMA_CNT_READ_EN exposes counter reads
module snd_dma_addr
    import gstmcu_snd_pkg::*;
(
    input  logic              clk32,
    input  logic              porb,
    input  logic              reg_sel,
    input  logic              reg_wr,
    input  logic [4:0]        reg_a,
    input  logic [7:0]        reg_di,
    output logic [7:0]        reg_do,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] snd,
    output logic [ADDR_W-1:0] sft,
    output logic              sndon,
    output logic              sfrep,
    output logic              sfend
);

    logic              wr_en;
    logic              ctrl_wr;
    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] end_q;
    logic [7:0]        start_hi, start_mi, start_lo;
    logic [7:0]        end_hi, end_mi, end_lo;

    snd_state_e        state, state_nxt;
    logic              rep_q, rep_nxt;
    logic [ADDR_W-1:0] snd_q, snd_nxt;
    logic [ADDR_W-1:0] sft_q, sft_nxt;
    logic              sfend_q, sfend_nxt;

    assign wr_en   = reg_sel & reg_wr;
    assign ctrl_wr = wr_en && (reg_a == REG_CTRL);

    snd_addr_reg u_start (
        .clk32 (clk32),
        .porb  (porb),
        .wr_hi (wr_en && (reg_a == REG_START_HI)),
        .wr_mi (wr_en && (reg_a == REG_START_MI)),
        .wr_lo (wr_en && (reg_a == REG_START_LO)),
        .di    (reg_di),
        .q     (start_q),
        .do_hi (start_hi),
        .do_mi (start_mi),
        .do_lo (start_lo)
    );

    snd_addr_reg u_end (
        .clk32 (clk32),
        .porb  (porb),
        .wr_hi (wr_en && (reg_a == REG_END_HI)),
        .wr_mi (wr_en && (reg_a == REG_END_MI)),
        .wr_lo (wr_en && (reg_a == REG_END_LO)),
        .di    (reg_di),
        .q     (end_q),
        .do_hi (end_hi),
        .do_mi (end_mi),
        .do_lo (end_lo)
    );

    always_ff @(posedge clk32 or negedge porb) begin
        if (!porb) begin
            state   <= ST_IDLE;
            rep_q   <= 1'b0;
            snd_q   <= '0;
            sft_q   <= '0;
            sfend_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            rep_q   <= rep_nxt;
            snd_q   <= snd_nxt;
            sft_q   <= sft_nxt;
            sfend_q <= sfend_nxt;
        end
    end

    // Reloads read start_q/end_q, i.e. the value held before any coincident register write.
    always_comb begin
        state_nxt = state;
        rep_nxt   = rep_q;
        snd_nxt   = snd_q;
        sft_nxt   = sft_q;
        sfend_nxt = 1'b0;
        if (ctrl_wr) rep_nxt = reg_di[CTRL_REP_BIT];
        case (state)
            ST_IDLE: begin
                if (ctrl_wr && reg_di[CTRL_PLAY_BIT]) begin
                    state_nxt = ST_PLAY;
                    snd_nxt   = start_q;
                    sft_nxt   = end_q;
                end
            end
            ST_PLAY: begin
                if (ctrl_wr && !reg_di[CTRL_PLAY_BIT]) begin
                    state_nxt = ST_IDLE;
                end else if (fetch_en) begin
                    if (snd_q != sft_q) begin
                        snd_nxt = snd_q + 1'b1;
                    end else begin
                        sfend_nxt = 1'b1;
                        if (rep_q) begin
                            snd_nxt = start_q;
                            sft_nxt = end_q;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        reg_do = 8'h00;
        case (reg_a)
            REG_CTRL:     reg_do = {6'b000000, rep_q, state == ST_PLAY};
            REG_START_HI: reg_do = start_hi;
            REG_START_MI: reg_do = start_mi;
            REG_START_LO: reg_do = start_lo;
`ifdef SNDDMA_CNT_READ_EN
            REG_CNT_HI:   reg_do = addr_hi_byte(snd_q);
            REG_CNT_MI:   reg_do = addr_mi_byte(snd_q);
            REG_CNT_LO:   reg_do = addr_lo_byte(snd_q);
`endif
            REG_END_HI:   reg_do = end_hi;
            REG_END_MI:   reg_do = end_mi;
            REG_END_LO:   reg_do = end_lo;
            default:      reg_do = 8'h00;
        endcase
    end

    assign snd   = snd_q;
    assign sft   = sft_q;
    assign sndon = (state == ST_PLAY);
    assign sfrep = rep_q;
    assign sfend = sfend_q;

endmodule

// File: doc/snd_dma_addr.md
SND_DMA_ADDR -- requirements
Module: snd_dma_addr

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, named as below.
REQ-002 clk32  in  1  system clock; all state updates on its rising edge.
REQ-003 porb  in  1  asynchronous active-low power-on reset.
REQ-004 reg_sel  in  1  CPU cycle addresses the sound DMA register window (FF8900-FF8913).
REQ-005 reg_wr  in  1  one-clk32 write strobe, qualified by reg_sel.
REQ-006 reg_a  in  5  word index (address bits 5:1) inside the window.
REQ-007 reg_di  in  8  write data, low byte lane.
REQ-008 reg_do  out  8  read data for reg_a; combinational.
REQ-009 fetch_en  in  1  one-clk32 pulse per sound word fetched by the downstream control stage (its sndclk/sload timing).
REQ-010 snd  out  21  current word address, bits 21:1.
REQ-011 sft  out  21  latched frame-end word address, bits 21:1.
REQ-012 sndon  out  1  DMA play enable.
REQ-013 sfrep  out  1  repeat-mode enable.
REQ-014 sfend  out  1  one-clk32 pulse when a frame completes.

Function
REQ-015 Register map by reg_a: 0 control (bit0 play, bit1 repeat); 1/2/3 start high/mid/low; 4/5/6 counter high/mid/low (read-only); 7/8/9 end high/mid/low; others read 0x00 and ignore writes.
REQ-016 High bytes SHALL hold address bits 21:16 (bits 7:6 read 0); low bytes SHALL hold bits 7:1 (bit0 reads 0, write ignored).
REQ-017 Register writes SHALL take effect on the clk32 edge where reg_sel & reg_wr is high.
REQ-018 State machine: IDLE, PLAY.
REQ-019 IDLE -> PLAY on a control write with play=1: snd <= start register, sft <= end register, same edge.
REQ-020 In PLAY, a control write with play=1 SHALL update only the repeat bit; no reload.
REQ-021 In PLAY, a control write with play=0 SHALL enter IDLE next edge; snd holds its value; a coincident fetch_en is discarded.
REQ-022 In PLAY, fetch_en with snd != sft SHALL increment snd by 1 word, wrapping at 21 bits (0x1FFFFF -> 0x000000).
REQ-023 In PLAY, fetch_en with snd == sft SHALL pulse sfend for one cycle; with repeat=1, snd <= start and sft <= end (frame reload, stay in PLAY); with repeat=0, play bit clears and state -> IDLE, snd holds.
REQ-024 A start/end write on the same edge as a frame reload SHALL be stored in the register; the reload uses the pre-write value.
REQ-025 Start/end writes while in PLAY SHALL NOT affect snd/sft until the next reload or start.
REQ-026 sndon SHALL equal (state == PLAY); sfrep SHALL equal the repeat bit.
REQ-027 fetch_en in IDLE SHALL be ignored.

Reset
REQ-028 porb low SHALL asynchronously force: state IDLE, play=0, repeat=0, start=end=0, snd=sft=0, sfend=0.
REQ-029 Reset asserted mid-frame SHALL abort without a sfend pulse.

Configuration
REQ-030 Macro SNDDMA_CNT_READ_EN: when defined, reg_a 4/5/6 SHALL return the snd bytes; when undefined they SHALL read 0x00 and the counter read mux is omitted.

Structure
REQ-031 Shared package gstmcu_snd_pkg SHALL hold register index constants, control bit positions and the state enum.
REQ-032 One sub-module snd_addr_reg (21-bit three-byte writable address register with byte-lane write and read-back) SHALL be instantiated for start and end.

Verification
REQ-033 Reset, write start=0x010000, end=0x010008, control=0x01 -> sndon=1, snd=0x008000, sft=0x008004.
REQ-034 From REQ-033, four fetch_en pulses -> snd=0x008004; fifth pulse -> sfend one cycle, sndon=0, snd stays 0x008004.
REQ-035 Same setup with control=0x03 -> on fifth pulse sfend=1, snd=0x008000, sndon stays 1; end rewritten to 0x010010 mid-frame takes effect after that reload only.
REQ-036 start=0x3FFFFE, end=0x000002, play -> fetch_en wraps snd 0x1FFFFF -> 0x000000 -> 0x000001 then frame end.
REQ-037 Control write play=0 coincident with fetch_en -> IDLE, snd unchanged, no sfend; porb pulse mid-frame -> all outputs 0.
REQ-038 Read reg_a=6 after two fetches from 0x010000: 0x04 with SNDDMA_CNT_READ_EN, 0x00 without.
